// File: rtl/ghr_checkpoint_ctrl.sv
// ghr_checkpoint_ctrl: speculative/committed global history with an in-flight prediction FIFO and flush recovery
module ghr_checkpoint_ctrl #(
  parameter int depth = 4,
  parameter int NUM_CKPT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pred_valid,
  input  logic                        pred_taken,
  output logic                        pred_ready,
  input  logic                        resolve_valid,
  input  logic                        resolve_taken,
  output logic                        resolve_ready,
  input  logic                        squash,
  output logic [depth-1:0]            spec_ghr,
  output logic [depth-1:0]            commit_ghr,
  output logic                        mispredict,
  output logic                        flush,
  output logic [$clog2(NUM_CKPT+1)-1:0] inflight
);
  localparam int PW = $clog2(NUM_CKPT);
  localparam int CW = $clog2(NUM_CKPT+1);
  typedef enum logic {RUN, RECOVER} state_t;
  state_t state, state_nxt;
  logic [NUM_CKPT-1:0] fifo;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic pred_acc, res_acc, mis_nxt, flush_nxt;
  logic [depth-1:0] commit_nxt, spec_nxt;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(NUM_CKPT-1) ? '0 : p + 1'b1;
  endfunction
  assign pred_ready = state == RUN && inflight != CW'(NUM_CKPT);
  assign resolve_ready = state == RUN && inflight != '0;
  always_comb begin
    pred_acc = pred_valid & pred_ready;
    res_acc = resolve_valid & resolve_ready;
    mis_nxt = res_acc && resolve_taken != fifo[rd_ptr];
    flush_nxt = mis_nxt | squash;
    commit_nxt = res_acc ? {commit_ghr[depth-2:0], resolve_taken} : commit_ghr;
    // recovery rebuilds from the post-resolve committed history; wrong-path predictions are dropped
    spec_nxt = flush_nxt ? commit_nxt : pred_acc ? {spec_ghr[depth-2:0], pred_taken} : spec_ghr;
    state_nxt = flush_nxt ? RECOVER : RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      spec_ghr <= '1;
      commit_ghr <= '1;
      inflight <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo <= '0;
      mispredict <= 1'b0;
      flush <= 1'b0;
    end else begin
      state <= state_nxt;
      spec_ghr <= spec_nxt;
      commit_ghr <= commit_nxt;
      mispredict <= mis_nxt;
      flush <= flush_nxt;
      inflight <= flush_nxt ? '0 : inflight + CW'(pred_acc) - CW'(res_acc);
      wr_ptr <= flush_nxt ? '0 : pred_acc ? inc(wr_ptr) : wr_ptr;
      rd_ptr <= flush_nxt ? '0 : res_acc ? inc(rd_ptr) : rd_ptr;
      if (pred_acc) fifo[wr_ptr] <= pred_taken;
    end
  end
endmodule

// File: tb/tb_ghr_checkpoint_ctrl.sv
// tb_ghr_checkpoint_ctrl: table-driven vectors with a scoreboard queue of expected post-edge outputs
module tb_ghr_checkpoint_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pred_valid = 1'b0, pred_taken = 1'b0, resolve_valid = 1'b0, resolve_taken = 1'b0, squash = 1'b0;
  logic pred_ready, resolve_ready, mispredict, flush;
  logic [3:0] spec_ghr, commit_ghr;
  logic [2:0] inflight;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic pv, pt, rv, rt, sq, rs;
    logic [3:0] spec, commit;
    logic [2:0] inf;
    logic pr, rr, mis, fl;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  always #5 clk = ~clk;
  ghr_checkpoint_ctrl #(.depth(4), .NUM_CKPT(4)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ready(pred_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_ready(resolve_ready),
    .squash(squash), .spec_ghr(spec_ghr), .commit_ghr(commit_ghr),
    .mispredict(mispredict), .flush(flush), .inflight(inflight)
  );
  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %0b want %0b", nm, idx, act, exp);
    end
  endtask
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    {pred_valid, pred_taken, resolve_valid, resolve_taken, squash, rst} = {v.pv, v.pt, v.rv, v.rt, v.sq, v.rs};
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("spec_ghr", idx, spec_ghr, e.spec);
    chk("commit_ghr", idx, commit_ghr, e.commit);
    chk("inflight", idx, {1'b0, inflight}, {1'b0, e.inf});
    chk("pred_ready", idx, {3'b0, pred_ready}, {3'b0, e.pr});
    chk("resolve_ready", idx, {3'b0, resolve_ready}, {3'b0, e.rr});
    chk("mispredict", idx, {3'b0, mispredict}, {3'b0, e.mis});
    chk("flush", idx, {3'b0, flush}, {3'b0, e.fl});
  endtask
  initial begin
    //              pv  pt  rv  rt  sq  rs   spec     commit   inf   pr  rr  mis fl
    tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 4'b1111, 4'b1111, 3'd0, 1'b1,1'b0,1'b0,1'b0}); // reset
    tbl.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b1110, 4'b1111, 3'd1, 1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 4'b1101, 4'b1111, 3'd2, 1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b1010, 4'b1111, 3'd3, 1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0100, 4'b1111, 3'd4, 1'b0,1'b1,1'b0,1'b0}); // full
    tbl.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 4'b0100, 4'b1111, 3'd4, 1'b0,1'b1,1'b0,1'b0}); // 5th ignored
    tbl.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 4'b0100, 4'b1110, 3'd3, 1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 4'b0100, 4'b1101, 3'd2, 1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0, 4'b1011, 4'b1011, 3'd0, 1'b0,1'b0,1'b1,1'b1}); // mispredict
    tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b1011, 4'b1011, 3'd0, 1'b1,1'b0,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 4'b0111, 4'b1011, 3'd1, 1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b1110, 4'b1011, 3'd2, 1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0, 4'b1101, 4'b0111, 3'd2, 1'b1,1'b1,1'b0,1'b0}); // pred+resolve
    tbl.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b1010, 4'b0111, 3'd3, 1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 4'b0111, 4'b0111, 3'd0, 1'b0,1'b0,1'b0,1'b1}); // squash
    tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 4'b1111, 4'b1111, 3'd0, 1'b1,1'b0,1'b0,1'b0}); // rst in RECOVER
    tbl.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 4'b1111, 4'b1111, 3'd1, 1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 4'b1111, 4'b1111, 3'd0, 1'b0,1'b0,1'b0,1'b1});
    tbl.push_back('{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 4'b1111, 4'b1111, 3'd0, 1'b0,1'b0,1'b0,1'b1}); // squash in RECOVER
    tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b1111, 4'b1111, 3'd0, 1'b1,1'b0,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b1110, 4'b1111, 3'd1, 1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0, 4'b1111, 4'b1111, 3'd0, 1'b0,1'b0,1'b1,1'b1}); // mispredict+squash
    tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b1111, 4'b1111, 3'd0, 1'b1,1'b0,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 4'b1111, 4'b1111, 3'd0, 1'b1,1'b0,1'b0,1'b0}); // resolve on empty
    tbl.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b1110, 4'b1111, 3'd1, 1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 4'b1110, 4'b1110, 3'd0, 1'b0,1'b0,1'b0,1'b1}); // correct+squash
    tbl.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b1110, 4'b1110, 3'd0, 1'b1,1'b0,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 4'b1101, 4'b1110, 3'd1, 1'b1,1'b1,1'b0,1'b0}); // pointer wrap run
    tbl.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 4'b1011, 4'b1110, 3'd2, 1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0110, 4'b1110, 3'd3, 1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 4'b0110, 4'b1101, 3'd2, 1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 4'b0110, 4'b1011, 3'd1, 1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b1100, 4'b1011, 3'd2, 1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 4'b1001, 4'b1011, 3'd3, 1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 4'b1001, 4'b0110, 3'd2, 1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 4'b1001, 4'b1100, 3'd1, 1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 4'b1001, 4'b1001, 3'd0, 1'b1,1'b0,1'b0,1'b0});
    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) apply(tbl[i], i);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
